qar_gpio_responder: RTL and testbench
=====================================

Name: qar_gpio_responder

Overview:
- Memory-mapped GPIO peripheral; responder on the qar_core data bus (mem_valid/mem_we/mem_addr/mem_wdata initiator side → mem_ready/mem_rdata responder side).
- Provides direction/output registers, synchronised and glitch-filtered inputs, and rising-edge interrupt capture with W1C status.
- Selected by the interconnect; decodes only the low address offset.

Parameters:
- WIDTH, 32, number of GPIO pins (1..32); unused register bits read 0.
- FILTER_W, 16, width of the filter threshold register and per-pin counters.
- FILTER_DEFAULT, 16, reset value of the FILTER register, in cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- mem_valid  in  1  access request, held until mem_ready
- mem_we  in  1  1=write, 0=read
- mem_addr  in  8  byte offset; [1:0] ignored
- mem_wdata  in  32  write data
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, valid while mem_ready=1
- gpio_in  in  WIDTH  asynchronous pin inputs
- gpio_out  out  WIDTH  output register
- gpio_dir  out  WIDTH  1=output
- gpio_irq  out  1  OR of IRQ_STATUS

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Register map, 32-bit words:
  - 0x00 DIR (RW)
  - 0x04 OUT (RW)
  - 0x08 IN (RO, filtered value)
  - 0x0C IRQ_RISE_EN (RW)
  - 0x10 IRQ_STATUS (R/W1C)
  - 0x14 FILTER (RW, low FILTER_W bits)
  - 0x18 IRQ_FALL_EN (see Optional Feature)
  - Other offsets read 0; writes are ignored; the access still completes.
- Handshake:
  - An access is accepted on a rising edge where mem_valid=1 and mem_ready=0.
  - mem_ready goes to 1 on the next cycle for exactly one cycle, so latency is 1 cycle.
  - A write commits on the acceptance edge.
  - Read data is registered at acceptance. mem_rdata holds its last value when mem_ready=0.
  - mem_valid seen while mem_ready=1 is not a new access. Back-to-back accesses therefore complete every 2 cycles.
- Reset values:
  - mem_ready=0, mem_rdata=0
  - DIR=0, OUT=0, IRQ_RISE_EN=0, IRQ_FALL_EN=0, IRQ_STATUS=0, FILTER=FILTER_DEFAULT
  - synchroniser flops=0, filtered=0, counters=0, gpio_irq=0
- Reset mid-access clears mem_ready. Any accepted write not yet committed is discarded, and no completion pulse is issued.
- Input path:
  - Each pin passes through a 2-flop synchroniser (s2).
  - Per-pin filter counter:
    - If s2==filtered, the counter is cleared.
    - Otherwise the counter increments.
    - When the counter reaches FILTER-1, filtered takes s2 on that edge and the counter clears.
  - FILTER=0 or 1 gives bypass: filtered follows s2 one cycle later.
  - Pin-to-IN latency: 2 + FILTER cycles.
  - A pulse shorter than FILTER cycles, measured at s2, never changes filtered.
  - Counters saturate at the all-ones value and never wrap.
  - A FILTER write takes effect on the next cycle; running counters are not cleared.
- Interrupts:
  - Edge detection compares filtered against its value one cycle earlier (filtered_d).
  - Rising edge with IRQ_RISE_EN[i]=1 sets IRQ_STATUS[i].
  - A W1C write clears the bits written as 1.
  - Set and clear on the same edge for the same bit: set wins.
  - Enables do not gate already-set status bits.
  - gpio_irq=|IRQ_STATUS, registered, so it lags status by 0 cycles (same flop stage).
- Read of IRQ_STATUS or IN in the same cycle as an update returns the pre-update value.

Optional Feature:
- Macro: QAR_GPIO_FALL_IRQ_EN.
- Defined:
  - 0x18 IRQ_FALL_EN is RW.
  - A falling edge of filtered with IRQ_FALL_EN[i]=1 sets IRQ_STATUS[i].
  - Rising and falling edges share the same status bit, with the same set-wins rule.
- Undefined:
  - 0x18 reads 0; writes are ignored.
  - No falling-edge logic is generated.

Test Plan:
- Reset, then write DIR=0x000000FF and read DIR back → mem_ready pulses 1 cycle after each accepted access; read returns 0x000000FF; gpio_dir=0x000000FF.
- IRQ_RISE_EN=0x100, FILTER=16; gpio_in[8] high for 100 cycles, then low → IN reads 0x100 during the pulse; IRQ_STATUS=0x00000100; gpio_irq=1; after the pulse plus 20 cycles, IN reads 0x00000000.
- FILTER=16; gpio_in[3] high for 5 cycles with IRQ_RISE_EN=0x8 → IN never shows bit 3; IRQ_STATUS stays 0.
- Bit 8 status set; write 0x100 to IRQ_STATUS on the same edge as a new filtered rise on pin 8 → status remains 0x100; a later W1C with no edge → status 0, gpio_irq=0.
- Assert rst during a pending write to OUT → OUT=0; mem_ready=0 the next cycle; a read of an unmapped offset 0x40 → returns 0 with a normal 1-cycle ready.
- With QAR_GPIO_FALL_IRQ_EN defined: IRQ_FALL_EN=0x1; pin 0 falls after being high → IRQ_STATUS=0x1. With the macro undefined, reading 0x18 returns 0.

Source files
------------

// File: rtl/qar_gpio_responder.sv
// GPIO responder on the qar_core data bus: DIR/OUT registers, synchronised and
// glitch-filtered inputs, edge-triggered W1C interrupt status. Falling-edge IRQs: QAR_GPIO_FALL_IRQ_EN.
module qar_gpio_responder #(
    parameter int WIDTH          = 32,
    parameter int FILTER_W       = 16,
    parameter int FILTER_DEFAULT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic             mem_we,
    input  logic [7:0]       mem_addr,
    input  logic [31:0]      mem_wdata,
    output logic             mem_ready,
    output logic [31:0]      mem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_dir,
    output logic             gpio_irq
);
    localparam logic [5:0] OFF_DIR  = 6'h0;
    localparam logic [5:0] OFF_OUT  = 6'h1;
    localparam logic [5:0] OFF_IN   = 6'h2;
    localparam logic [5:0] OFF_RISE = 6'h3;
    localparam logic [5:0] OFF_STAT = 6'h4;
    localparam logic [5:0] OFF_FILT = 6'h5;
    localparam logic [5:0] OFF_FALL = 6'h6;

    logic [WIDTH-1:0]    dir_q, out_q, rise_en_q, status_q, status_nxt, edge_set, w1c;
    logic [WIDTH-1:0]    sync1_q, sync2_q, filt_q, filt_d_q, filt_nxt;
    logic [FILTER_W-1:0] filter_q, thr;
    logic [FILTER_W-1:0] cnt_q   [WIDTH];
    logic [FILTER_W-1:0] cnt_nxt [WIDTH];
    logic                bypass, accept, wr_en;
    logic [5:0]          off;
    logic [31:0]         rd_data;
    logic                unused_ok;
`ifdef QAR_GPIO_FALL_IRQ_EN
    logic [WIDTH-1:0]    fall_en_q;
`endif

    // A cycle with mem_ready high is the completion slot, never a new access.
    assign accept    = mem_valid & ~mem_ready;
    assign wr_en     = accept & mem_we;
    assign off       = mem_addr[7:2];
    assign unused_ok = &{1'b0, mem_addr[1:0], mem_wdata};

    assign gpio_out = out_q;
    assign gpio_dir = dir_q;

    always_comb begin
        rd_data = '0;
        case (off)
            OFF_DIR:  rd_data[WIDTH-1:0]    = dir_q;
            OFF_OUT:  rd_data[WIDTH-1:0]    = out_q;
            OFF_IN:   rd_data[WIDTH-1:0]    = filt_q;
            OFF_RISE: rd_data[WIDTH-1:0]    = rise_en_q;
            OFF_STAT: rd_data[WIDTH-1:0]    = status_q;
            OFF_FILT: rd_data[FILTER_W-1:0] = filter_q;
`ifdef QAR_GPIO_FALL_IRQ_EN
            OFF_FALL: rd_data[WIDTH-1:0]    = fall_en_q;
`endif
            default:  ;
        endcase
    end

    // FILTER of 0 or 1 means no debounce; >= keeps a lowered threshold from stranding a counter.
    assign thr    = filter_q - FILTER_W'(1);
    assign bypass = (filter_q <= FILTER_W'(1));

    always_comb begin
        filt_nxt = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = cnt_q[i];
            if (sync2_q[i] == filt_q[i]) begin
                cnt_nxt[i] = '0;
            end else if (bypass || (cnt_q[i] >= thr)) begin
                filt_nxt[i] = sync2_q[i];
                cnt_nxt[i]  = '0;
            end else if (cnt_q[i] != '1) begin
                cnt_nxt[i] = cnt_q[i] + FILTER_W'(1);
            end
        end
    end

`ifdef QAR_GPIO_FALL_IRQ_EN
    assign edge_set = (filt_q & ~filt_d_q & rise_en_q) | (~filt_q & filt_d_q & fall_en_q);
`else
    assign edge_set = filt_q & ~filt_d_q & rise_en_q;
`endif
    // Set is OR-ed in after the clear so a coincident edge wins.
    assign w1c        = (wr_en && (off == OFF_STAT)) ? mem_wdata[WIDTH-1:0] : '0;
    assign status_nxt = (status_q & ~w1c) | edge_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            status_q  <= '0;
            filter_q  <= FILTER_W'(FILTER_DEFAULT);
            sync1_q   <= '0;
            sync2_q   <= '0;
            filt_q    <= '0;
            filt_d_q  <= '0;
            gpio_irq  <= 1'b0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
`ifdef QAR_GPIO_FALL_IRQ_EN
            fall_en_q <= '0;
`endif
        end else begin
            sync1_q   <= gpio_in;
            sync2_q   <= sync1_q;
            filt_q    <= filt_nxt;
            filt_d_q  <= filt_q;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_nxt[i];
            status_q  <= status_nxt;
            gpio_irq  <= |status_nxt;
            mem_ready <= accept;
            if (accept) mem_rdata <= rd_data;
            if (wr_en) begin
                case (off)
                    OFF_DIR:  dir_q     <= mem_wdata[WIDTH-1:0];
                    OFF_OUT:  out_q     <= mem_wdata[WIDTH-1:0];
                    OFF_RISE: rise_en_q <= mem_wdata[WIDTH-1:0];
                    OFF_FILT: filter_q  <= mem_wdata[FILTER_W-1:0];
`ifdef QAR_GPIO_FALL_IRQ_EN
                    OFF_FALL: fall_en_q <= mem_wdata[WIDTH-1:0];
`endif
                    default:  ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qar_gpio_responder.sv
// Directed and randomized bench for qar_gpio_responder with a cycle-stepped reference model.
module tb_qar_gpio_responder;
    logic        clk = 1'b0;
    logic        rst, mem_valid, mem_we, mem_ready, gpio_irq;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata, gpio_in, gpio_out, gpio_dir;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit [31:0] m_dir, m_out, m_rise, m_fall, m_status, m_s1, m_s2, m_filt, m_filtd, m_rdata;
    bit        m_ready;
    int        m_filter;
    int        run [32];

    qar_gpio_responder #(.WIDTH(32), .FILTER_W(16), .FILTER_DEFAULT(16)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_dir(gpio_dir), .gpio_irq(gpio_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] m_read(input bit [7:0] a);
        case (a[7:2])
            6'd0: return m_dir;
            6'd1: return m_out;
            6'd2: return m_filt;
            6'd3: return m_rise;
            6'd4: return m_status;
            6'd5: return 32'(m_filter);
`ifdef QAR_GPIO_FALL_IRQ_EN
            6'd6: return m_fall;
`endif
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge: advance the model with the inputs present at the edge, then compare.
    task automatic tick();
        bit [31:0] edges, w1c, rd;
        bit        acc;
        @(posedge clk);
        if (rst) begin
            {m_dir, m_out, m_rise, m_fall, m_status, m_s1, m_s2, m_filt, m_filtd, m_rdata} = '0;
            m_ready  = 1'b0;
            m_filter = 16;
            for (int i = 0; i < 32; i++) run[i] = 0;
        end else begin
            acc   = mem_valid && !m_ready;
            rd    = m_read(mem_addr);
            edges = m_filt & ~m_filtd & m_rise;
`ifdef QAR_GPIO_FALL_IRQ_EN
            edges |= ~m_filt & m_filtd & m_fall;
`endif
            w1c = (acc && mem_we && mem_addr[7:2] == 6'd4) ? mem_wdata : 32'h0;
            m_filtd = m_filt;
            // A pin flips once s2 has disagreed for FILTER consecutive cycles (at least one).
            for (int i = 0; i < 32; i++) begin
                if (m_s2[i] != m_filt[i]) begin
                    run[i]++;
                    if (run[i] >= ((m_filter < 1) ? 1 : m_filter)) begin
                        m_filt[i] = m_s2[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = gpio_in;
            m_status = (m_status & ~w1c) | edges;
            if (acc && mem_we) begin
                case (mem_addr[7:2])
                    6'd0: m_dir  = mem_wdata;
                    6'd1: m_out  = mem_wdata;
                    6'd3: m_rise = mem_wdata;
                    6'd5: m_filter = int'(mem_wdata[15:0]);
`ifdef QAR_GPIO_FALL_IRQ_EN
                    6'd6: m_fall = mem_wdata;
`endif
                    default: ;
                endcase
            end
            m_ready = acc;
            if (acc) m_rdata = rd;
        end
        #1;
        chk("ready", mem_ready, m_ready);
        chk("rdata", mem_rdata, m_rdata);
        chk("gpio_out", gpio_out, m_out);
        chk("gpio_dir", gpio_dir, m_dir);
        chk("gpio_irq", gpio_irq, |m_status);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic access(input bit we, input bit [7:0] a, input bit [31:0] d, output logic [31:0] r);
        mem_valid = 1'b1; mem_we = we; mem_addr = a; mem_wdata = d;
        tick();
        r = mem_rdata;
        chk("ready_pulse", mem_ready, 1);
        mem_valid = 1'b0;
        tick();
        chk("ready_low", mem_ready, 0);
    endtask

    task automatic wr(input bit [7:0] a, input bit [31:0] d);
        logic [31:0] r;
        access(1'b1, a, d, r);
    endtask

    task automatic rd_chk(input string tag, input bit [7:0] a, input bit [31:0] exp);
        logic [31:0] r;
        access(1'b0, a, 32'h0, r);
        chk(tag, r, exp);
    endtask

    initial begin
        logic [31:0] r;
        bit found;
        rst = 1'b1; mem_valid = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; gpio_in = '0;
        hold(2);
        chk("rst_ready", mem_ready, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_dir", gpio_dir, 0);
        chk("rst_irq", gpio_irq, 0);
        rst = 1'b0;
        hold(1);
        rd_chk("rst_filter", 8'h14, 32'd16);
        rd_chk("rst_status", 8'h10, 32'h0);

        wr(8'h00, 32'h0000_00FF);
        rd_chk("dir_rb", 8'h00, 32'h0000_00FF);
        chk("gpio_dir_ff", gpio_dir, 32'h0000_00FF);

        // Long pulse on pin 8 passes the filter and raises an interrupt.
        wr(8'h0C, 32'h100);
        wr(8'h14, 32'd16);
        gpio_in = 32'h100;
        hold(40);
        rd_chk("in_pulse", 8'h08, 32'h100);
        rd_chk("stat_pulse", 8'h10, 32'h100);
        chk("irq_pulse", gpio_irq, 1);
        hold(56);
        gpio_in = 32'h0;
        hold(20);
        rd_chk("in_after", 8'h08, 32'h0);

        // Short glitch on pin 3 is rejected.
        wr(8'h10, 32'h100);
        wr(8'h0C, 32'h8);
        gpio_in = 32'h8;
        hold(5);
        gpio_in = 32'h0;
        hold(30);
        rd_chk("glitch_stat", 8'h10, 32'h0);
        rd_chk("glitch_in", 8'h08, 32'h0);

        // W1C on the same edge as a new rise: set wins.
        wr(8'h0C, 32'h100);
        wr(8'h14, 32'd2);
        gpio_in = 32'h100; hold(10);
        gpio_in = 32'h0;   hold(10);
        gpio_in = 32'h100;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_filt[8] && !m_filtd[8]) found = 1'b1;
            else tick();
        end
        chk("setwins_edge_found", 32'(found), 1);
        wr(8'h10, 32'h100);
        rd_chk("setwins_stat", 8'h10, 32'h100);
        wr(8'h10, 32'h100);
        hold(2);
        rd_chk("w1c_stat", 8'h10, 32'h0);
        chk("w1c_irq", gpio_irq, 0);

        // Reset lands on the acceptance edge of a write to OUT.
        wr(8'h04, 32'h5A);
        chk("out_5a", gpio_out, 32'h5A);
        mem_valid = 1'b1; mem_we = 1'b1; mem_addr = 8'h04; mem_wdata = 32'hA5; rst = 1'b1;
        tick();
        chk("rst_mid_out", gpio_out, 32'h0);
        chk("rst_mid_ready", mem_ready, 0);
        rst = 1'b0; mem_valid = 1'b0;
        tick();
        chk("rst_mid_ready2", mem_ready, 0);
        rd_chk("unmapped_40", 8'h40, 32'h0);

`ifdef QAR_GPIO_FALL_IRQ_EN
        wr(8'h18, 32'h1);
        gpio_in = 32'h1; hold(30);
        gpio_in = 32'h0; hold(30);
        rd_chk("fall_stat", 8'h10, 32'h1);
        wr(8'h10, 32'h1);
`else
        wr(8'h18, 32'hFFFF_FFFF);
        rd_chk("fall_absent", 8'h18, 32'h0);
`endif

        // Randomized traffic checked cycle by cycle against the model.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 6))
                0: begin gpio_in = $urandom; hold($urandom_range(1, 8)); end
                1: wr(8'h14, $urandom_range(0, 4));
                2: wr(8'h0C, $urandom);
                3: wr(8'h18, $urandom);
                4: wr(8'h10, $urandom);
                5: access(1'b0, 8'($urandom_range(0, 18) * 4 + $urandom_range(0, 3)), 32'h0, r);
                default: wr(8'($urandom_range(0, 1) * 4), $urandom);
            endcase
        end
        rd_chk("final_in", 8'h08, m_read(8'h08));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
